// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode and control-field encodings for the multicycle MIPS controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    RWB, IEXEC, IWB, BRANCH, JUMP, HALT, ILLEGAL
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_HLT = 6'h3F;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the shared multicycle MIPS datapath
// Ports: clk/rst_n (async active-low); opcode = IR[31:26]; mem_ready = memory
// completes this cycle; datapath enables and mux selects; halted/illegal status;
// instr_count = retired instructions (wraps). Optional MC_ILLEGAL_TRAP_EN traps
// unlisted opcodes into a sticky ILLEGAL state instead of treating them as NOPs.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             irwrite,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  state_t state, next;
  logic retire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      instr_count <= '0;
    end else begin
      state <= next;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  always_comb begin
    next = state;
    retire = 1'b0;
    {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, regdst, regwrite, alusrca} = '0;
    alusrcb = SRCB_B;
    aluop = ALUOP_ADD;
    pcsource = PCSRC_ALU;
    halted = 1'b0;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (opcode)
          OP_RTYPE: next = EXEC;
          OP_ADDI, OP_ADDIU: next = IEXEC;
          OP_LW, OP_SW: next = MEMADR;
          OP_BEQ: next = BRANCH;
          OP_J: next = JUMP;
          OP_HLT: begin
            next = HALT;
            retire = 1'b1;
          end
`ifdef MC_ILLEGAL_TRAP_EN
          default: next = ILLEGAL;
`else
          default: begin
            next = FETCH;
            retire = 1'b1;
          end
`endif
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next = opcode == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread = 1'b1;
        iord = 1'b1;
        next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord = 1'b1;
        retire = mem_ready;
        next = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop = ALUOP_FUNCT;
        next = RWB;
      end
      RWB: begin
        regwrite = 1'b1;
        regdst = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next = IWB;
      end
      IWB: begin
        regwrite = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource = PCSRC_ALUOUT;
        retire = 1'b1;
        next = FETCH;
      end
      JUMP: begin
        pcwrite = 1'b1;
        pcsource = PCSRC_JUMP;
        retire = 1'b1;
        next = FETCH;
      end
      HALT: halted = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
      ILLEGAL: halted = 1'b1;
`endif
      default: next = FETCH;
    endcase
  end
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = state == ILLEGAL;
`else
  assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized scoreboard bench for multicycle_control
module tb_multicycle_control;
  typedef struct packed {
    logic [17:0] w;
    logic [31:0] c;
  } exp_t;
  // word layout: pcwrite pcwritecond iord memread memwrite memtoreg irwrite regdst regwrite alusrca alusrcb aluop pcsource halted illegal
  localparam logic [17:0] W_FETCH_NR = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] W_FETCH_R  = 18'b1_0_0_1_0_0_1_0_0_0_01_00_00_0_0;
  localparam logic [17:0] W_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] W_MEMADR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] W_MEMRD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] W_MEMWB    = 18'b0_0_0_0_0_1_0_0_1_0_00_00_00_0_0;
  localparam logic [17:0] W_MEMWR    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] W_EXEC     = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] W_RWB      = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [17:0] W_IEXEC    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] W_IWB      = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [17:0] W_BRANCH   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [17:0] W_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
  localparam logic [17:0] W_HALT     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] W_ILL      = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic mem_ready = 1'b0;
  logic pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;
  logic halted, illegal;
  logic [31:0] instr_count;
  logic pcwrite4, pcwritecond4, iord4, memread4, memwrite4, memtoreg4, irwrite4, regdst4, regwrite4, alusrca4;
  logic [1:0] alusrcb4, aluop4, pcsource4;
  logic halted4, illegal4;
  logic [3:0] instr_count4;
  logic [17:0] word;
  exp_t q[$];
  logic [31:0] cnt = 0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );
  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite4), .pcwritecond(pcwritecond4), .iord(iord4), .memread(memread4),
    .memwrite(memwrite4), .memtoreg(memtoreg4), .irwrite(irwrite4), .regdst(regdst4),
    .regwrite(regwrite4), .alusrca(alusrca4), .alusrcb(alusrcb4), .aluop(aluop4),
    .pcsource(pcsource4), .halted(halted4), .illegal(illegal4), .instr_count(instr_count4)
  );
  assign word = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, regdst,
                 regwrite, alusrca, alusrcb, aluop, pcsource, halted, illegal};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctrl", {14'b0, word}, {14'b0, e.w});
      chk("count", instr_count, e.c);
      chk("count4", {28'b0, instr_count4}, {28'b0, e.c[3:0]});
      chk("ctrl4", {14'b0, pcwrite4, pcwritecond4, iord4, memread4, memwrite4, memtoreg4, irwrite4,
                    regdst4, regwrite4, alusrca4, alusrcb4, aluop4, pcsource4, halted4, illegal4},
          {14'b0, e.w});
    end
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic cycle(input logic [17:0] w, input logic mr);
    mem_ready = mr;
    q.push_back('{w: w, c: cnt});
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    cnt = 0;
    q.push_back('{w: W_FETCH_NR, c: 0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic sticky(input logic [17:0] w);
    repeat (4) begin
      opcode = 6'($urandom);
      cycle(w, rb());
    end
  endtask
  function automatic logic stops(input logic [5:0] op);
`ifdef MC_ILLEGAL_TRAP_EN
    return !(op inside {6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02});
`else
    return op == 6'h3F;
`endif
  endfunction
  // one instruction from fetch to retirement; fw/mw < 0 pick random wait counts
  task automatic instr(input logic [5:0] op, input int fw, input int mw);
    int n;
    opcode = op;
    n = fw < 0 ? int'($urandom_range(0, 2)) : fw;
    repeat (n) cycle(W_FETCH_NR, 1'b0);
    cycle(W_FETCH_R, 1'b1);
    cycle(W_DECODE, rb());
    n = mw < 0 ? int'($urandom_range(0, 2)) : mw;
    case (op)
      6'h23: begin
        cycle(W_MEMADR, rb());
        repeat (n) cycle(W_MEMRD, 1'b0);
        cycle(W_MEMRD, 1'b1);
        cycle(W_MEMWB, rb());
        cnt++;
      end
      6'h2B: begin
        cycle(W_MEMADR, rb());
        repeat (n) cycle(W_MEMWR, 1'b0);
        cycle(W_MEMWR, 1'b1);
        cnt++;
      end
      6'h00: begin
        cycle(W_EXEC, rb());
        cycle(W_RWB, rb());
        cnt++;
      end
      6'h08, 6'h09: begin
        cycle(W_IEXEC, rb());
        cycle(W_IWB, rb());
        cnt++;
      end
      6'h04: begin
        cycle(W_BRANCH, rb());
        cnt++;
      end
      6'h02: begin
        cycle(W_JUMP, rb());
        cnt++;
      end
      6'h3F: begin
        cnt++;
        sticky(W_HALT);
      end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        sticky(W_ILL);
`else
        cnt++;
`endif
      end
    endcase
  endtask
  initial begin
    logic [5:0] ops [10];
    ops = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h3E, 6'h15};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr(6'h00, 0, 0);
    opcode = 6'h23;
    cycle(W_FETCH_R, 1'b1);
    cycle(W_DECODE, 1'b0);
    cycle(W_MEMADR, 1'b0);
    mem_ready = 1'b0;
    q.push_back('{w: W_MEMRD, c: cnt});
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_memread", {31'b0, memread}, 1);
    chk("rst_regwrite", {31'b0, regwrite}, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_word", {14'b0, word}, {14'b0, W_FETCH_NR});
    @(posedge clk);
    #1;
    rst_pulse();
    instr(6'h23, 0, 0);
    instr(6'h2B, 0, 3);
    instr(6'h00, 2, 0);
    rst_pulse();
    instr(6'h08, -1, -1);
    instr(6'h04, -1, -1);
    instr(6'h02, -1, -1);
    instr(6'h3F, -1, -1);
    chk("hlt_count", instr_count, 4);
    chk("hlt_sticky", {31'b0, halted}, 1);
    rst_pulse();
    instr(6'h3E, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    chk("ill_count", instr_count, 0);
    chk("ill_flag", {31'b0, illegal}, 1);
`else
    chk("nop_count", instr_count, 1);
    chk("nop_flag", {31'b0, illegal}, 0);
`endif
    rst_pulse();
    repeat (15) instr(6'h00, 0, 0);
    chk("pre_wrap4", {28'b0, instr_count4}, 15);
    instr(6'h00, 0, 0);
    chk("wrap4", {28'b0, instr_count4}, 0);
    chk("wrap32", instr_count, 16);
    repeat (150) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 9)];
      instr(op, -1, -1);
      if (stops(op)) rst_pulse();
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
